// File: rtl/calc_sequencer.sv
// Calculator sequencer: latches operands on an op strobe, runs add/sub/mul/div,
// converts the magnitude to BCD and holds the four display digit codes.
module calc_sequencer #(
  parameter int OP_W  = 7,
  parameter int RES_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      op_pulse,
  input  logic            ret_pulse,
  input  logic [OP_W-1:0] num1,
  input  logic [OP_W-1:0] num2,
  output logic            busy,
  output logic            done,
  output logic            show_result,
  output logic            is_negative,
  output logic            div_zero,
  output logic [15:0]     digits_out
);

  localparam int CNT_W = $clog2(RES_W);

  typedef enum logic [2:0] {IDLE, EXEC, CONV, DONE, SHOW} seqState;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} seqOp;

  seqState state, stateNext;
  seqOp    opReg, opDecoded;
  logic    opValid;

  logic latch, execStep, execLast, convStep, convLast;
  logic [CNT_W-1:0] cnt, execLastCnt;

  logic [OP_W-1:0]  a, b, mplier;
  logic [RES_W-1:0] acc, mcand;
  logic [OP_W+1:0]  dvd, remShift;
  logic [OP_W:0]    rem, divisor;
  logic             qBit;
  logic             isNeg, divZero;
  logic [15:0]      bcd, adj, bcdNext, digitsReg;

  always_comb begin
    opValid   = 1'b0;
    opDecoded = OP_ADD;
    case (op_pulse)
      4'b0001: begin opValid = 1'b1; opDecoded = OP_ADD; end
      4'b0010: begin opValid = 1'b1; opDecoded = OP_SUB; end
      4'b0100: begin opValid = 1'b1; opDecoded = OP_MUL; end
      4'b1000: begin opValid = 1'b1; opDecoded = OP_DIV; end
      default: ;
    endcase
  end

  always_comb begin
    case (opReg)
      OP_MUL:  execLastCnt = CNT_W'(OP_W - 1);
      OP_DIV:  execLastCnt = CNT_W'(OP_W + 1);
      default: execLastCnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    busy        = 1'b0;
    done        = 1'b0;
    show_result = 1'b0;
    latch       = 1'b0;
    execStep    = 1'b0;
    execLast    = 1'b0;
    convStep    = 1'b0;
    convLast    = 1'b0;
    case (state)
      IDLE, SHOW: begin
        show_result = (state == SHOW);
        if (ret_pulse) begin
          stateNext = IDLE;
        end else if (opValid) begin
          latch     = 1'b1;
          stateNext = EXEC;
        end
      end
      EXEC: begin
        busy = 1'b1;
        if (ret_pulse) begin
          stateNext = IDLE;
        end else begin
          execStep = 1'b1;
          if (cnt == execLastCnt) begin
            execLast  = 1'b1;
            stateNext = CONV;
          end
        end
      end
      CONV: begin
        busy = 1'b1;
        if (ret_pulse) begin
          stateNext = IDLE;
        end else begin
          convStep = 1'b1;
          if (cnt == CNT_W'(RES_W - 1)) begin
            convLast  = 1'b1;
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = ret_pulse ? IDLE : SHOW;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Restoring divide step: 2b divisor against the shifted partial remainder.
  always_comb begin
    divisor  = {b, 1'b0};
    remShift = {rem, dvd[OP_W+1]};
    qBit     = (remShift >= {1'b0, divisor});
  end

  // Double-dabble adjust, then shift the next binary bit in (MSB first).
  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcdNext = 16'({adj, acc[RES_W-1]});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opReg     <= OP_ADD;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      mplier    <= '0;
      acc       <= '0;
      mcand     <= '0;
      dvd       <= '0;
      rem       <= '0;
      isNeg     <= 1'b0;
      divZero   <= 1'b0;
      bcd       <= '0;
      digitsReg <= '0;
    end else if (latch) begin
      opReg   <= opDecoded;
      cnt     <= '0;
      a       <= num1;
      b       <= num2;
      mplier  <= num2;
      acc     <= '0;
      mcand   <= RES_W'(num1);
      dvd     <= {1'b0, num1, 1'b0} + (OP_W+2)'(num2);
      rem     <= '0;
      isNeg   <= 1'b0;
      divZero <= 1'b0;
      bcd     <= '0;
    end else if (execStep) begin
      cnt <= execLast ? '0 : cnt + CNT_W'(1);
      case (opReg)
        OP_ADD: acc <= RES_W'(a) + RES_W'(b);
        OP_SUB: begin
          if (a < b) begin
            acc   <= RES_W'(b - a);
            isNeg <= 1'b1;
          end else begin
            acc <= RES_W'(a - b);
          end
        end
        OP_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        OP_DIV: begin
          // Zero divisor still burns the full EXEC length with a zero result.
          if (b == '0) begin
            divZero <= 1'b1;
          end else begin
            rem <= (OP_W+1)'(qBit ? remShift - {1'b0, divisor} : remShift);
            acc <= {acc[RES_W-2:0], qBit};
            dvd <= dvd << 1;
          end
        end
      endcase
    end else if (convStep) begin
      cnt <= convLast ? '0 : cnt + CNT_W'(1);
      bcd <= bcdNext;
      acc <= acc << 1;
      if (convLast) digitsReg <= isNeg ? {4'd11, 4'd10, bcdNext[7:0]} : bcdNext;
    end
  end

  assign is_negative = isNeg;
  assign div_zero    = divZero;
  assign digits_out  = digitsReg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized and directed bench for calc_sequencer against an arithmetic reference model.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  op_pulse = '0;
  logic        ret_pulse = 1'b0;
  logic [6:0]  num1 = '0;
  logic [6:0]  num2 = '0;
  logic        busy, done, show_result, is_negative, div_zero;
  logic [15:0] digits_out;

  int errCnt = 0;
  int chkCnt = 0;
  int lastDigits = 0;

  calc_sequencer #(.OP_W(7), .RES_W(14)) dut (
    .clk(clk), .rst(rst), .op_pulse(op_pulse), .ret_pulse(ret_pulse),
    .num1(num1), .num2(num2), .busy(busy), .done(done),
    .show_result(show_result), .is_negative(is_negative),
    .div_zero(div_zero), .digits_out(digits_out)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    chkCnt++;
    if (got != exp) begin
      errCnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // op index: 0 add, 1 sub, 2 mul, 3 div
  function automatic int refResult(input int op, input int x, input int y);
    int q;
    case (op)
      0: return x + y;
      1: return (x >= y) ? x - y : y - x;
      2: return x * y;
      default: begin
        if (y == 0) return 0;
        q = x / y;
        if (2 * (x % y) >= y) q++;
        return q;
      end
    endcase
  endfunction

  function automatic int refDigits(input int op, input int x, input int y);
    int r;
    r = refResult(op, x, y);
    if (op == 1 && x < y) return (11 << 12) | (10 << 8) | ((r / 10) << 4) | (r % 10);
    return (((r / 1000) % 10) << 12) | (((r / 100) % 10) << 8) | (((r / 10) % 10) << 4) | (r % 10);
  endfunction

  function automatic int refLatency(input int op);
    if (op < 2) return 16;
    return (op == 2) ? 22 : 24;
  endfunction

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".busy"}, int'(busy), 0);
    checkVal({tag, ".done"}, int'(done), 0);
    checkVal({tag, ".show"}, int'(show_result), 0);
    checkVal({tag, ".neg"}, int'(is_negative), 0);
    checkVal({tag, ".divZero"}, int'(div_zero), 0);
    checkVal({tag, ".digits"}, int'(digits_out), 0);
  endtask

  task automatic runOp(input int op, input int x, input int y, input bit scramble, input int injectCyc);
    int cyc;
    int expD;
    expD = refDigits(op, x, y);
    @(negedge clk);
    num1 = 7'(x);
    num2 = 7'(y);
    op_pulse = 4'(1 << op);
    @(posedge clk); #1;
    op_pulse = '0;
    cyc = 1;
    checkVal("execBusy", int'(busy), 1);
    checkVal("execShowOff", int'(show_result), 0);
    while (!done && cyc < 40) begin
      if (scramble) begin
        num1 = 7'($urandom_range(0, 99));
        num2 = 7'($urandom_range(0, 99));
      end
      op_pulse = (cyc == injectCyc) ? 4'b0100 : 4'b0000;
      @(posedge clk); #1;
      cyc++;
    end
    op_pulse = '0;
    checkVal($sformatf("latency op%0d %0d,%0d", op, x, y), cyc, refLatency(op));
    checkVal($sformatf("digits op%0d %0d,%0d", op, x, y), int'(digits_out), expD);
    checkVal("isNegative", int'(is_negative), int'(op == 1 && x < y));
    checkVal("divZero", int'(div_zero), int'(op == 3 && y == 0));
    @(posedge clk); #1;
    checkVal("showOn", int'(show_result), 1);
    checkVal("showBusyOff", int'(busy), 0);
    checkVal("doneOneCycle", int'(done), 0);
    checkVal("digitsHeld", int'(digits_out), expD);
    lastDigits = expD;
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checkVal(tag, seen, 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset");
    @(negedge clk) rst = 1'b1;

    runOp(0, 45, 67, 1'b0, 0);
    runOp(1, 12, 45, 1'b0, 0);
    runOp(1, 45, 45, 1'b0, 0);
    runOp(2, 99, 99, 1'b1, 0);
    runOp(3, 7, 2, 1'b0, 0);
    runOp(3, 10, 4, 1'b0, 0);
    runOp(3, 5, 0, 1'b0, 0);
    runOp(0, 3, 4, 1'b0, 3);

    // Abort a multiply with ret_pulse during cycle 5.
    @(negedge clk);
    num1 = 7'd12; num2 = 7'd34; op_pulse = 4'b0100;
    @(posedge clk); #1;
    op_pulse = '0;
    repeat (4) begin @(posedge clk); #1; end
    ret_pulse = 1'b1;
    @(posedge clk); #1;
    ret_pulse = 1'b0;
    checkVal("abort.busy", int'(busy), 0);
    checkVal("abort.show", int'(show_result), 0);
    checkVal("abort.digits", int'(digits_out), lastDigits);
    watchNoDone("abort.noDone", 30);

    // ret_pulse in SHOW returns to input display, digits held.
    runOp(0, 20, 30, 1'b0, 0);
    @(negedge clk) ret_pulse = 1'b1;
    @(posedge clk); #1;
    ret_pulse = 1'b0;
    checkVal("ret.show", int'(show_result), 0);
    checkVal("ret.busy", int'(busy), 0);
    checkVal("ret.digits", int'(digits_out), lastDigits);

    // Simultaneous op and ret in SHOW: ret wins.
    runOp(2, 13, 7, 1'b0, 0);
    @(negedge clk);
    op_pulse = 4'b0001; ret_pulse = 1'b1;
    @(posedge clk); #1;
    op_pulse = '0; ret_pulse = 1'b0;
    checkVal("opRet.show", int'(show_result), 0);
    checkVal("opRet.busy", int'(busy), 0);
    @(posedge clk); #1;
    checkVal("opRet.busyLater", int'(busy), 0);

    // Non-one-hot strobe ignored.
    @(negedge clk) op_pulse = 4'b0011;
    @(posedge clk); #1;
    op_pulse = '0;
    checkVal("multiHot.busy", int'(busy), 0);
    watchNoDone("multiHot.noDone", 20);

    // Reset during cycle 10 of a divide.
    @(negedge clk);
    num1 = 7'd50; num2 = 7'd7; op_pulse = 4'b1000;
    @(posedge clk); #1;
    op_pulse = '0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1 checkAllZero("midReset");
    @(negedge clk) rst = 1'b1;
    watchNoDone("midReset.noDone", 30);

    for (int n = 0; n < 24; n++) begin
      int op, x, y, inj;
      op  = int'($urandom_range(0, 3));
      x   = int'($urandom_range(0, 99));
      y   = int'($urandom_range(0, 99));
      if ($urandom_range(0, 4) == 0) y = 0;
      inj = int'($urandom_range(0, 8));
      runOp(op, x, y, 1'($urandom_range(0, 1)), inj);
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errCnt, chkCnt);
    $fatal(1, "timeout");
  end

endmodule
